// File: rtl/mispredict_redirect_if.sv
// rtl/mispredict_redirect_if.sv - selected-branch input and redirect/flush output bundle
interface mispredict_redirect_if;
   logic [75:0] IN_branch;
   logic        IN_robFlush;
   logic        OUT_redirValid;
   logic [31:0] OUT_redirPC;
   logic [15:0] OUT_redirHistory;
   logic [4:0]  OUT_redirFetchID;
   logic        OUT_redirRetStack;
   logic        OUT_mispredFlush;
   logic [6:0]  OUT_flushSqN;
   logic [6:0]  OUT_flushLoadSqN;
   logic [6:0]  OUT_flushStoreSqN;

   modport master (
      output IN_branch, IN_robFlush,
      input  OUT_redirValid, OUT_redirPC, OUT_redirHistory, OUT_redirFetchID,
             OUT_redirRetStack, OUT_mispredFlush, OUT_flushSqN, OUT_flushLoadSqN,
             OUT_flushStoreSqN
   );

   modport slave (
      input  IN_branch, IN_robFlush,
      output OUT_redirValid, OUT_redirPC, OUT_redirHistory, OUT_redirFetchID,
             OUT_redirRetStack, OUT_mispredFlush, OUT_flushSqN, OUT_flushLoadSqN,
             OUT_flushStoreSqN
   );
endinterface

// File: rtl/mispredict_redirect.sv
// rtl/mispredict_redirect.sv - registers the oldest mispredict, redirects fetch, holds flush window
module mispredict_redirect #(
   parameter int FLUSH_CYCLES = 3
) (
   input logic               clk,
   input logic               rst,
   mispredict_redirect_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

   localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic        capture;
   logic        br_older;
   logic [6:0]  age_diff;

   logic        redir_q;
   logic [31:0] pc_q;
   logic [15:0] hist_q;
   logic [4:0]  fid_q;
   logic        ret_q;
   logic [6:0]  sqn_q;
   logic [6:0]  lsqn_q;
   logic [6:0]  ssqn_q;

   logic        br_valid;
   logic [31:0] br_pc;
   logic [6:0]  br_sqn;
   logic [6:0]  br_lsqn;
   logic [6:0]  br_ssqn;
   logic        br_ret;
   logic [4:0]  br_fid;
   logic [15:0] br_hist;

   assign br_pc    = bus.IN_branch[75:44];
   assign br_sqn   = bus.IN_branch[43:37];
   assign br_lsqn  = bus.IN_branch[36:30];
   assign br_ssqn  = bus.IN_branch[29:23];
   assign br_ret   = bus.IN_branch[22];
   assign br_fid   = bus.IN_branch[21:17];
   assign br_hist  = bus.IN_branch[16:1];
   assign br_valid = bus.IN_branch[0];

   // State and window counter; a ROB flush or reset drops back to IDLE at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         redir_q <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         redir_q <= capture;
      end
   end

   // Captured branch fields; held while idle so consumers can qualify with the strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= 32'd0;
         hist_q <= 16'd0;
         fid_q  <= 5'd0;
         ret_q  <= 1'b0;
         sqn_q  <= 7'd0;
         lsqn_q <= 7'd0;
         ssqn_q <= 7'd0;
      end else if (capture) begin
         pc_q   <= br_pc;
         hist_q <= br_hist;
         fid_q  <= br_fid;
         ret_q  <= br_ret;
         sqn_q  <= br_sqn;
         lsqn_q <= br_lsqn;
         ssqn_q <= br_ssqn;
      end
   end

   // Next state: capture when idle or when the branch is older (wrap-safe) than the one in flight
   always_comb begin
      age_diff = br_sqn - sqn_q;
      br_older = age_diff[6];
      capture  = br_valid && !bus.IN_robFlush && ((state == IDLE) || br_older);
      state_d  = state;
      cnt_d    = cnt;
      if (bus.IN_robFlush) begin
         state_d = IDLE;
      end else if (capture) begin
         state_d = FLUSH;
         cnt_d   = CNT_RELOAD;
      end else if (state == FLUSH) begin
         if (cnt == 4'd0) begin
            state_d = IDLE;
         end else begin
            cnt_d = cnt - 4'd1;
         end
      end
   end

   // Outputs come straight from registers
   always_comb begin
      bus.OUT_redirValid    = redir_q;
      bus.OUT_redirPC       = pc_q;
      bus.OUT_redirHistory  = hist_q;
      bus.OUT_redirFetchID  = fid_q;
      bus.OUT_redirRetStack = ret_q;
      bus.OUT_mispredFlush  = (state == FLUSH);
      bus.OUT_flushSqN      = sqn_q;
      bus.OUT_flushLoadSqN  = lsqn_q;
      bus.OUT_flushStoreSqN = ssqn_q;
   end
endmodule

// File: tb/tb_mispredict_redirect.sv
// tb/tb_mispredict_redirect.sv - scoreboard bench for mispredict_redirect at FLUSH_CYCLES 3 and 1
module tb_mispredict_redirect;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mispredict_redirect_if bus0 ();
   mispredict_redirect_if bus1 ();

   mispredict_redirect #(.FLUSH_CYCLES(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   mispredict_redirect #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   typedef struct {
      logic        redir;
      logic        flush;
      logic [31:0] pc;
      logic [15:0] hist;
      logic [4:0]  fid;
      logic        ret;
      logic [6:0]  sqn;
      logic [6:0]  lsqn;
      logic [6:0]  ssqn;
   } exp_t;

   exp_t exp_q0[$];
   exp_t exp_q1[$];

   int   checks = 0;
   int   errors = 0;

   // Reference model: window length counted as cycles remaining, held fields per instance
   int   fc [2] = '{3, 1};
   bit   m_busy [2];
   int   m_left [2];
   exp_t m_hold [2];

   function automatic bit older(input int a, input int b);
      return ((a - b) & 127) >= 64;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0;
         m_left[k] = 0;
         m_hold[k] = '{redir: 1'b0, flush: 1'b0, pc: 32'd0, hist: 16'd0, fid: 5'd0,
                       ret: 1'b0, sqn: 7'd0, lsqn: 7'd0, ssqn: 7'd0};
      end
   endtask

   task automatic model_step(input int k, input logic [75:0] br, input logic rob, output exp_t e);
      bit cap;
      cap = !rob && br[0] && (!m_busy[k] || older(int'(br[43:37]), int'(m_hold[k].sqn)));
      if (rob) begin
         m_busy[k] = 1'b0;
      end else if (cap) begin
         m_busy[k]      = 1'b1;
         m_left[k]      = fc[k];
         m_hold[k].pc   = br[75:44];
         m_hold[k].sqn  = br[43:37];
         m_hold[k].lsqn = br[36:30];
         m_hold[k].ssqn = br[29:23];
         m_hold[k].ret  = br[22];
         m_hold[k].fid  = br[21:17];
         m_hold[k].hist = br[16:1];
      end else if (m_busy[k]) begin
         m_left[k] = m_left[k] - 1;
         if (m_left[k] == 0) m_busy[k] = 1'b0;
      end
      e       = m_hold[k];
      e.redir = cap;
      e.flush = m_busy[k];
   endtask

   task automatic cmp(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic check_one(input string tag, input exp_t e, input exp_t a);
      cmp({tag, ".redirValid"}, a.redir, e.redir);
      cmp({tag, ".mispredFlush"}, a.flush, e.flush);
      cmp({tag, ".flushSqN"}, a.sqn, e.sqn);
      cmp({tag, ".flushLoadSqN"}, a.lsqn, e.lsqn);
      cmp({tag, ".flushStoreSqN"}, a.ssqn, e.ssqn);
      if (e.redir && a.redir) begin
         cmp({tag, ".redirPC"}, a.pc, e.pc);
         cmp({tag, ".redirHistory"}, a.hist, e.hist);
         cmp({tag, ".redirFetchID"}, a.fid, e.fid);
         cmp({tag, ".redirRetStack"}, a.ret, e.ret);
      end
   endtask

   function automatic exp_t sample0();
      exp_t a;
      a = '{redir: bus0.OUT_redirValid, flush: bus0.OUT_mispredFlush, pc: bus0.OUT_redirPC,
            hist: bus0.OUT_redirHistory, fid: bus0.OUT_redirFetchID, ret: bus0.OUT_redirRetStack,
            sqn: bus0.OUT_flushSqN, lsqn: bus0.OUT_flushLoadSqN, ssqn: bus0.OUT_flushStoreSqN};
      return a;
   endfunction

   function automatic exp_t sample1();
      exp_t a;
      a = '{redir: bus1.OUT_redirValid, flush: bus1.OUT_mispredFlush, pc: bus1.OUT_redirPC,
            hist: bus1.OUT_redirHistory, fid: bus1.OUT_redirFetchID, ret: bus1.OUT_redirRetStack,
            sqn: bus1.OUT_flushSqN, lsqn: bus1.OUT_flushLoadSqN, ssqn: bus1.OUT_flushStoreSqN};
      return a;
   endfunction

   // Monitor: after every active edge, pop the expectation issued for that edge and compare
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check_one("fc3", e, sample0());
         end
         if (!rst && exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check_one("fc1", e, sample1());
         end
      end
   end

   // Drive one cycle of stimulus on both instances and queue the model's expectation
   task automatic step(input logic v, input logic [31:0] pc, input logic [6:0] sqn, input logic rob);
      logic [75:0] br;
      exp_t        e;
      logic [6:0]  lsqn, ssqn;
      logic [4:0]  fid;
      logic [15:0] hist;
      logic        ret;
      lsqn = 7'($urandom);
      ssqn = 7'($urandom);
      fid  = 5'($urandom);
      hist = 16'($urandom);
      ret  = 1'($urandom);
      @(negedge clk);
      br = {pc, sqn, lsqn, ssqn, ret, fid, hist, v};
      bus0.IN_branch   = br;
      bus1.IN_branch   = br;
      bus0.IN_robFlush = rob;
      bus1.IN_robFlush = rob;
      model_step(0, br, rob, e);
      exp_q0.push_back(e);
      model_step(1, br, rob, e);
      exp_q1.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 7'd0, 1'b0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      exp_t zero;
      zero = '{redir: 1'b0, flush: 1'b0, pc: 32'd0, hist: 16'd0, fid: 5'd0,
               ret: 1'b0, sqn: 7'd0, lsqn: 7'd0, ssqn: 7'd0};
      rst = 1'b1;
      bus0.IN_branch   = 76'd0;
      bus1.IN_branch   = 76'd0;
      bus0.IN_robFlush = 1'b0;
      bus1.IN_robFlush = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      release_reset();

      // Put both instances mid-flush, then reset between edges
      step(1'b1, 32'hDEAD_BEE0, 7'd33, 1'b0);
      idle(1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_one("async_rst.fc3", zero, sample0());
      check_one("async_rst.fc1", zero, sample1());
      exp_q0.delete();
      exp_q1.delete();
      model_reset();
      bus0.IN_branch = 76'd0;
      bus1.IN_branch = 76'd0;
      repeat (2) @(posedge clk);
      release_reset();

      // First capture and full window
      step(1'b1, 32'h0000_1000, 7'd10, 1'b0);
      idle(5);

      // Older branch one cycle into the window
      step(1'b1, 32'h0000_3000, 7'd20, 1'b0);
      step(1'b1, 32'h0000_2000, 7'd15, 1'b0);
      idle(5);

      // Newer and equal branches are dropped
      step(1'b1, 32'h0000_4000, 7'd20, 1'b0);
      step(1'b1, 32'h0000_5000, 7'd25, 1'b0);
      step(1'b1, 32'h0000_6000, 7'd20, 1'b0);
      idle(4);

      // Wrap-around age compare in both directions
      step(1'b1, 32'h0000_7000, 7'h02, 1'b0);
      step(1'b1, 32'h0000_8000, 7'h7F, 1'b0);
      idle(5);
      step(1'b1, 32'h0000_9000, 7'h7F, 1'b0);
      step(1'b1, 32'h0000_A000, 7'h02, 1'b0);
      idle(4);

      // ROB flush with an older branch mid-window, then in idle
      step(1'b1, 32'h0000_B000, 7'd40, 1'b0);
      step(1'b1, 32'h0000_C000, 7'd30, 1'b1);
      idle(2);
      step(1'b1, 32'h0000_D000, 7'd50, 1'b1);
      idle(2);

      // Older branch exactly on the last window cycle
      step(1'b1, 32'h0000_E000, 7'd60, 1'b0);
      idle(2);
      step(1'b1, 32'h0000_F000, 7'd55, 1'b0);
      idle(5);

      // Back-to-back older branches every cycle
      for (int i = 0; i < 5; i++) step(1'b1, 32'h0001_0000 + 32'(i), 7'(90 - i), 1'b0);
      idle(5);

      // Randomized traffic around the in-flight sqN
      for (int i = 0; i < 600; i++) begin
         logic [6:0] s;
         s = 7'(int'(m_hold[0].sqn) + $urandom_range(0, 20) - 10);
         step(1'($urandom_range(0, 1)), $urandom, s, $urandom_range(0, 15) == 0);
      end
      idle(6);
      @(posedge clk);
      #2;
      cmp("scoreboard_drained", exp_q0.size() + exp_q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mispredict_redirect.md
Name: mispredict_redirect

Overview:
- Sits directly downstream of the branch selector.
- Consumes the single oldest resolved mispredict per cycle and registers it.
- Issues a one-cycle front-end redirect (PC, history, fetch ID), then holds a multi-cycle mispredict-flush window.
- During the window it exports the flush sequence numbers used by ROB, rename and LSQ, and feeds the flush flag back to the selector's IN_mispredFlush.

Parameters:
- FLUSH_CYCLES, 3: length of the flush window in cycles, including the redirect cycle; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- IN_branch  in  76  selected branch, packed as follows:
  - [75:44] dstPC.
  - [43:37] sqN.
  - [36:30] loadSqN.
  - [29:23] storeSqN.
  - [22] flush-return-stack flag.
  - [21:17] fetchID.
  - [16:1] branch history.
  - [0] valid.
- IN_robFlush  in  1  exception/ROB flush; overrides everything.
- OUT_redirValid  out  1  one-cycle redirect strobe to fetch.
- OUT_redirPC  out  32  redirect target PC.
- OUT_redirHistory  out  16  restored branch history.
- OUT_redirFetchID  out  5  fetch ID of the mispredicting branch.
- OUT_redirRetStack  out  1  return-stack repair flag.
- OUT_mispredFlush  out  1  flush window active.
- OUT_flushSqN  out  7  sqN of the captured branch; ops strictly younger are killed.
- OUT_flushLoadSqN  out  7  load queue flush pointer.
- OUT_flushStoreSqN  out  7  store queue flush pointer.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high on rst, with clock clk.
  - All outputs and internal registers clear to 0; state goes to IDLE.
  - Reset mid-flush aborts immediately, with no redirect.
- All outputs are registered. Latency from IN_branch valid to OUT_redirValid is exactly 1 cycle.
- Age compare: A is older than B iff $signed(A - B) < 0, computed as a 7-bit wrap-around subtraction (handles sqN wrap, e.g. 7'h7E is older than 7'h01). Equal sqN is not older.
- States: IDLE, FLUSH.
- IDLE:
  - If IN_branch[0]=1 and IN_robFlush=0:
    - Capture all fields.
    - Next cycle: OUT_redirValid=1, redirect fields = captured, OUT_mispredFlush=1, flush SqNs = captured.
    - cnt <= FLUSH_CYCLES-1; go to FLUSH.
  - Otherwise stay in IDLE with OUT_redirValid=0 and OUT_mispredFlush=0.
- FLUSH:
  - OUT_mispredFlush=1; OUT_redirValid=0 except on the (re)capture cycle.
  - Each cycle: if cnt==0, go to IDLE next cycle with OUT_mispredFlush=0; else cnt <= cnt-1.
  - FLUSH_CYCLES=1: flush is asserted only on the redirect cycle, and the state returns to IDLE the next cycle.
- Older branch during FLUSH:
  - If IN_branch valid and its sqN is older than OUT_flushSqN: recapture, pulse OUT_redirValid again next cycle, and reload cnt = FLUSH_CYCLES-1 (window restarts).
  - Newer or equal sqN is dropped silently.
  - This takes priority over the cnt==0 exit in the same cycle.
- IN_robFlush:
  - Any state: go to IDLE next cycle, clear OUT_mispredFlush and OUT_redirValid, and ignore IN_branch that cycle.
  - Flush SqN outputs hold their last value.
- Redirect fields and flush SqN outputs hold their last captured values while idle; consumers qualify them with the strobes.
- No backpressure: the redirect is fire-and-forget, and fetch must accept it in the cycle it is presented.

Test Plan:
- Reset and first capture: assert rst asynchronously mid-cycle and check all outputs are 0 with no clk edge needed. Release, then drive valid, dstPC=32'h0000_1000, sqN=7'd10 for one cycle. Required next cycle: OUT_redirValid=1, OUT_redirPC=32'h1000, OUT_flushSqN=10, OUT_mispredFlush=1. With FLUSH_CYCLES=3, OUT_mispredFlush stays high exactly 3 cycles.
- Older branch mid-flush: capture sqN=20. One cycle later drive sqN=15, dstPC=32'h2000. Required: a second OUT_redirValid pulse with PC 32'h2000, OUT_flushSqN=15, and the window extends to 3 cycles after the recapture.
- Newer or equal branch mid-flush: capture sqN=20, then drive sqN=25, then sqN=20. Required: no additional redirect, OUT_flushSqN stays 20, and the window ends on schedule.
- Wrap-around: capture sqN=7'h02, then drive sqN=7'h7F. Required: 7'h7F is treated as older, so recapture and redirect occur. Conversely, capture 7'h7F and then drive 7'h02: the branch is dropped.
- ROB flush override:
  - Mid-FLUSH, assert IN_robFlush together with an older valid branch. Required: OUT_mispredFlush=0 next cycle, no redirect, state IDLE.
  - Repeat in IDLE with a valid branch: no capture occurs.
- Edge timing:
  - Older branch arriving exactly in the cnt==0 cycle: required recapture and restarted window.
  - FLUSH_CYCLES=1 with back-to-back older branches on consecutive cycles: a redirect pulse every cycle, and OUT_mispredFlush stays high until one idle cycle passes.
